// File: rtl/seq_restoring_divider_if.sv
// Handshake and result bundle for the sequential restoring divider.
// Handshake: start is a single-cycle request that the divider samples only when
// it is not busy (IDLE or DONE). The result is valid in the one cycle that done
// is high. quotient/remainder/div_by_zero then hold until the next completion.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic [1:0]       state_dbg;

    // Requester side: issues operands and observes results
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, state_dbg
    );

    // Divider side
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, state_dbg
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB
// first. Each step compares the partial remainder with the divisor and
// subtracts the divisor AND-masked by that compare flag.
module seq_restoring_divider #(
    parameter int WIDTH = 32
) (
    input logic                    clk,
    input logic                    rst,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   partial;
    logic             flag;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dvd_step;

    // One restoring step: bring down the next dividend bit, compare, subtract.
    // When flag is set the difference is below the divisor, so it fits in WIDTH
    // bits. The low-bit subtraction is therefore exact.
    always_comb begin
        partial  = {rem_q, dvd_q[WIDTH-1]};
        flag     = (partial >= {1'b0, dsr_q});
        rem_step = partial[WIDTH-1:0] - ({WIDTH{flag}} & dsr_q);
        dvd_step = {dvd_q[WIDTH-2:0], flag};
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    dvd_d = bus.dividend;
                    dsr_d = bus.divisor;
                    if (bus.divisor == '0) begin
                        // Division by zero resolves immediately, without iterating
                        state_d = ST_DONE;
                        quo_d   = '1;
                        rmd_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        rem_d   = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                rem_d = rem_step;
                dvd_d = dvd_step;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    quo_d   = dvd_step;
                    rmd_d   = rem_step;
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    // Status and results come straight from registers
    always_comb begin
        bus.busy        = (state_q == ST_RUN);
        bus.done        = (state_q == ST_DONE);
        bus.quotient    = quo_q;
        bus.remainder   = rmd_q;
        bus.div_by_zero = dbz_q;
        bus.state_dbg   = state_q;
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider. The driver pushes the expected
// result of each accepted operation into a queue, and an independent monitor
// pops and compares it whenever done is seen.
module tb_seq_restoring_divider;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] dvd;
    logic [W-1:0] dsr;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic [31:0]  acc;
  } exp_t;

  logic clk;
  logic rst;
  logic [31:0] cyc;
  int vectors;
  int miscompares;
  int busy_cnt;
  exp_t exp_q[$];

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer division
  function automatic exp_t model(input logic [W-1:0] dvd, input logic [W-1:0] dsr,
                                 input logic [31:0] acc);
    exp_t e;
    e.dvd = dvd;
    e.dsr = dsr;
    e.acc = acc;
    if (dsr == 0) begin
      e.q   = {W{1'b1}};
      e.r   = dvd;
      e.dbz = 1'b1;
    end else begin
      e.q   = dvd / dsr;
      e.r   = dvd % dsr;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_op(input logic [W-1:0] dvd, input logic [W-1:0] dsr);
    int guard = 0;
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (bus.busy) check("accept_timeout", 64'(bus.busy), 64'd0);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dsr;
    exp_q.push_back(model(dvd, dsr, cyc + 1));
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("quotient", 64'(bus.quotient), 64'(e.q));
          check("remainder", 64'(bus.remainder), 64'(e.r));
          check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
          check("latency", 64'(cyc), 64'(e.acc + (e.dbz ? 32'd0 : 32'(W))));
          check("busy_cycles", 64'(busy_cnt), e.dbz ? 64'd0 : 64'(W));
          check("busy_at_done", 64'(bus.busy), 64'd0);
          if (!e.dbz) begin
            check("invariant", 64'(bus.quotient) * 64'(e.dsr) + 64'(bus.remainder), 64'(e.dvd));
            check("rem_lt_dsr", 64'(bus.remainder < e.dsr), 64'd1);
          end
        end
        busy_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a, b;
    int guard;
    cyc          = 0;
    vectors      = 0;
    miscompares  = 0;
    busy_cnt     = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_quotient", 64'(bus.quotient), 64'd0);
    check("rst_remainder", 64'(bus.remainder), 64'd0);
    check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases
    do_op(32'd100, 32'd7);
    do_op(32'hFFFF_FFFF, 32'd1);
    do_op(32'd5, 32'd9);
    do_op(32'h8000_0000, 32'hFFFF_FFFF);
    do_op(32'd123, 32'd0);
    do_op(32'd77, 32'd0);     // back-to-back divide-by-zero
    do_op(32'd0, 32'd13);

    // Start while busy is ignored; the next real op issues in the DONE cycle
    do_op(32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd8;
    bus.divisor  = 32'd2;
    @(negedge clk);
    bus.start    = 1'b0;
    do_op(32'd100, 32'd7);

    // Asynchronous reset mid-operation
    do_op(32'd50, 32'd5);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_quotient", 64'(bus.quotient), 64'd0);
    check("midrst_remainder", 64'(bus.remainder), 64'd0);
    check("midrst_state", 64'(bus.state_dbg), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(32'd50, 32'd5);

    // Randomized operations
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = 32'd1;
        2, 3:    b = $urandom_range(1, 15);
        4:       b = $urandom_range(1, 65535);
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      do_op(a, b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Drain
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
